// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed BCD digit scanner with dead time, frame-synchronous update, leading-zero blanking; define SEG_DIM_EN for a dim input
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DIV = 12000,
  parameter int BLANK_CYC = 64,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
`ifdef SEG_DIM_EN
  input  logic [3:0]              dim,
`endif
  input  logic                    lz_blank_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);
  localparam int PW = $clog2(DIV);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
  logic [PW-1:0] pre;
  logic [SW-1:0] slot;
  logic [4*NUM_DIGITS-1:0] shadow, display;
  logic pending, boundary, on, show;
  logic [3:0] digit;
  logic [NUM_DIGITS-1:0] lz_mask, onehot;
  assign boundary = pre == PRE_LAST && slot == SLOT_LAST;
  assign digit = display[4*slot +: 4];
  assign onehot = NUM_DIGITS'(1) << slot;
  // lz_mask[k] is set when digit k and every digit above it are zero
  always_comb begin
    logic z;
    z = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z && display[4*k +: 4] == 4'd0;
      lz_mask[k] = z;
    end
  end
`ifdef SEG_DIM_EN
  logic [3:0] dim_q, dim_e;
  logic [31:0] on_end;
  assign dim_e = pre == '0 ? dim : dim_q;
  assign on_end = 32'(BLANK_CYC + (((DIV - BLANK_CYC) * (int'(dim_e) + 1)) >> 4));
  assign on = pre >= PRE_BLANK && 32'(pre) < on_end;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) dim_q <= 4'hF;
    else if (pre == '0) dim_q <= dim;
`else
  assign on = pre >= PRE_BLANK;
`endif
  assign show = on && !(lz_blank_en && slot != '0 && lz_mask[slot]);
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      slot <= '0;
      shadow <= '0;
      display <= '0;
      pending <= 1'b0;
      bcd_out <= 4'hF;
      digit_sel <= SEL_OFF;
      frame_tick <= 1'b0;
    end else begin
      pre <= pre == PRE_LAST ? '0 : pre + 1'b1;
      if (pre == PRE_LAST) slot <= slot == SLOT_LAST ? '0 : slot + 1'b1;
      if (load) shadow <= bcd_in;
      if (boundary) begin
        display <= load ? bcd_in : pending ? shadow : display;
        pending <= 1'b0;
      end else if (load) pending <= 1'b1;
      frame_tick <= boundary;
      bcd_out <= show ? digit : 4'hF;
      digit_sel <= show ? onehot ^ SEL_OFF : SEL_OFF;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with NUM_DIGITS=6, DIV=16, BLANK_CYC=2
module tb_seg_scan_ctrl;
  logic clk_sys = 1'b0, rst_n = 1'b1, load = 1'b0, lz_blank_en = 1'b0;
  logic [23:0] bcd_in = '0;
  logic [3:0] bcd_out, bcd_out_n;
  logic [5:0] digit_sel, digit_sel_n;
  logic frame_tick, frame_tick_n;
  int errors = 0, checks = 0;
`ifdef SEG_DIM_EN
  logic [3:0] dim = 4'd15;
`endif
  always #5 clk_sys = ~clk_sys;
  seg_scan_ctrl #(.NUM_DIGITS(6), .DIV(16), .BLANK_CYC(2), .SEL_ACTIVE_LOW(0)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
`ifdef SEG_DIM_EN
    .dim(dim),
`endif
    .lz_blank_en(lz_blank_en), .bcd_out(bcd_out), .digit_sel(digit_sel), .frame_tick(frame_tick));
  seg_scan_ctrl #(.NUM_DIGITS(6), .DIV(16), .BLANK_CYC(2), .SEL_ACTIVE_LOW(1)) dut_n (
    .clk_sys(clk_sys), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
`ifdef SEG_DIM_EN
    .dim(dim),
`endif
    .lz_blank_en(lz_blank_en), .bcd_out(bcd_out_n), .digit_sel(digit_sel_n), .frame_tick(frame_tick_n));
  // t = negedges since the counter was at frame position 0; outputs show position t-1
  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL %s_tick_timeout got=%b exp=1", tag, frame_tick); end
  endtask
  task automatic test_reset;
    #3 rst_n = 1'b0;
    step(2);
    checks++; if (digit_sel !== 6'b0) begin errors++; $display("FAIL reset_sel got=%b exp=000000", digit_sel); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL reset_bcd got=%h exp=f", bcd_out); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    checks++; if (digit_sel_n !== 6'b111111) begin errors++; $display("FAIL reset_sel_n got=%b exp=111111", digit_sel_n); end
    checks++; if (frame_tick_n !== 1'b0) begin errors++; $display("FAIL reset_tick_n got=%b exp=0", frame_tick_n); end
    rst_n = 1'b1;
    step(2);
    checks++; if (digit_sel !== 6'b0) begin errors++; $display("FAIL rel_blank_sel got=%b exp=000000", digit_sel); end
    step(1);
    checks++; if (digit_sel !== 6'b000001) begin errors++; $display("FAIL rel_first_sel got=%b exp=000001", digit_sel); end
    checks++; if (bcd_out !== 4'h0) begin errors++; $display("FAIL rel_first_bcd got=%h exp=0", bcd_out); end
    step(54);
    checks++; if (digit_sel !== 6'b001000) begin errors++; $display("FAIL slot3_sel got=%b exp=001000", digit_sel); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (digit_sel !== 6'b0) begin errors++; $display("FAIL async_sel got=%b exp=000000", digit_sel); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL async_bcd got=%h exp=f", bcd_out); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL async_tick got=%b exp=0", frame_tick); end
    checks++; if (digit_sel_n !== 6'b111111) begin errors++; $display("FAIL async_sel_n got=%b exp=111111", digit_sel_n); end
    step(1);
    rst_n = 1'b1;
    step(2);
    checks++; if (digit_sel !== 6'b0) begin errors++; $display("FAIL restart_blank_sel got=%b exp=000000", digit_sel); end
    step(1);
    checks++; if (digit_sel !== 6'b000001) begin errors++; $display("FAIL restart_sel got=%b exp=000001", digit_sel); end
  endtask
  task automatic test_scan;
    bcd_in = 24'h654321;
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_tick("scan");
    step(2);
    for (int k = 0; k < 6; k++) begin
      checks++; if (digit_sel !== 6'b0 || bcd_out !== 4'hF) begin errors++; $display("FAIL scan_blank slot=%0d got=%b/%h exp=000000/f", k, digit_sel, bcd_out); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL scan_tick_low slot=%0d got=%b exp=0", k, frame_tick); end
      step(1);
      checks++; if (digit_sel !== 6'(1 << k) || bcd_out !== 4'(k + 1)) begin errors++; $display("FAIL scan_on slot=%0d got=%b/%h exp=%b/%h", k, digit_sel, bcd_out, 6'(1 << k), 4'(k + 1)); end
      step(13);
      checks++; if (digit_sel !== 6'(1 << k) || bcd_out !== 4'(k + 1)) begin errors++; $display("FAIL scan_end slot=%0d got=%b/%h exp=%b/%h", k, digit_sel, bcd_out, 6'(1 << k), 4'(k + 1)); end
      checks++; if (frame_tick !== (k == 5)) begin errors++; $display("FAIL scan_tick slot=%0d got=%b exp=%b", k, frame_tick, k == 5); end
      step(2);
    end
  endtask
  task automatic test_tearing;
    step(38);
    bcd_in = 24'h999999;
    load = 1'b1;
    step(1);
    load = 1'b0;
    for (int k = 2; k < 6; k++) begin
      if (k > 2) step(16);
      checks++; if (digit_sel !== 6'(1 << k) || bcd_out !== 4'(k + 1)) begin errors++; $display("FAIL tear_hold slot=%0d got=%b/%h exp=%b/%h", k, digit_sel, bcd_out, 6'(1 << k), 4'(k + 1)); end
    end
    step(7);
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tear_tick got=%b exp=1", frame_tick); end
    step(3);
    checks++; if (digit_sel !== 6'b000001 || bcd_out !== 4'h9) begin errors++; $display("FAIL tear_new got=%b/%h exp=000001/9", digit_sel, bcd_out); end
    step(92);
    bcd_in = 24'h123456;
    load = 1'b1;
    step(1);
    load = 1'b0;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL coinc_tick got=%b exp=1", frame_tick); end
    checks++; if (digit_sel !== 6'b100000 || bcd_out !== 4'h9) begin errors++; $display("FAIL coinc_old got=%b/%h exp=100000/9", digit_sel, bcd_out); end
    step(3);
    checks++; if (digit_sel !== 6'b000001 || bcd_out !== 4'h6) begin errors++; $display("FAIL coinc_d0 got=%b/%h exp=000001/6", digit_sel, bcd_out); end
    step(87);
    checks++; if (digit_sel !== 6'b100000 || bcd_out !== 4'h1) begin errors++; $display("FAIL coinc_d5 got=%b/%h exp=100000/1", digit_sel, bcd_out); end
  endtask
  task automatic test_lz_blank;
    logic [3:0] dg [6] = '{4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0};
    lz_blank_en = 1'b1;
    bcd_in = 24'h000120;
    load = 1'b1;
    step(1);
    load = 1'b0;
    wait_tick("lz");
    step(3);
    for (int k = 0; k < 6; k++) begin
      checks++; if (digit_sel !== (k < 3 ? 6'(1 << k) : 6'b0) || bcd_out !== (k < 3 ? dg[k] : 4'hF)) begin errors++; $display("FAIL lz_on slot=%0d got=%b/%h exp=%b/%h", k, digit_sel, bcd_out, k < 3 ? 6'(1 << k) : 6'b0, k < 3 ? dg[k] : 4'hF); end
      step(16);
    end
    lz_blank_en = 1'b0;
    step(1);
    for (int k = 0; k < 6; k++) begin
      checks++; if (digit_sel !== 6'(1 << k) || bcd_out !== dg[k]) begin errors++; $display("FAIL lz_off slot=%0d got=%b/%h exp=%b/%h", k, digit_sel, bcd_out, 6'(1 << k), dg[k]); end
      step(16);
    end
    bcd_in = 24'h000000;
    load = 1'b1;
    lz_blank_en = 1'b1;
    step(1);
    load = 1'b0;
    wait_tick("lz_zero");
    step(3);
    for (int k = 0; k < 6; k++) begin
      checks++; if (digit_sel !== (k == 0 ? 6'b000001 : 6'b0) || bcd_out !== (k == 0 ? 4'h0 : 4'hF)) begin errors++; $display("FAIL lz_zero slot=%0d got=%b/%h", k, digit_sel, bcd_out); end
      step(16);
    end
  endtask
  task automatic test_polarity;
    lz_blank_en = 1'b0;
    step(14);
    checks++; if (digit_sel_n !== 6'b111111 || bcd_out_n !== 4'hF) begin errors++; $display("FAIL pol_off got=%b/%h exp=111111/f", digit_sel_n, bcd_out_n); end
    step(2);
    checks++; if (digit_sel_n !== 6'b111101 || bcd_out_n !== 4'h0) begin errors++; $display("FAIL pol_slot1 got=%b/%h exp=111101/0", digit_sel_n, bcd_out_n); end
    checks++; if (digit_sel !== 6'b000010) begin errors++; $display("FAIL pol_ref got=%b exp=000010", digit_sel); end
  endtask
`ifdef SEG_DIM_EN
  task automatic test_dim;
    int cnt;
    dim = 4'd7;
    step(14);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (digit_sel !== 6'b0) cnt++;
      step(1);
    end
    checks++; if (cnt !== 7) begin errors++; $display("FAIL dim7_on got=%0d exp=7", cnt); end
    dim = 4'd15;
    step(16);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (digit_sel !== 6'b0) cnt++;
      step(1);
    end
    checks++; if (cnt !== 14) begin errors++; $display("FAIL dim15_on got=%0d exp=14", cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_lz_blank();
    test_polarity();
`ifdef SEG_DIM_EN
    test_dim();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
